// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI register responder: FSM state encoding,
// read/write command codes, default status byte and command field positions.
`timescale 1ns/1ps
package spi_pkg;

    // Transaction phases of the responder
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA    = 2'd2,
        WAIT_CS = 2'd3
    } state_t;

    // Value of the R/W bit in the command byte
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Byte shifted out on miso while the command byte is being received
    localparam logic [7:0] STATUS_BYTE_DEFAULT = 8'hA5;

    // Command byte layout: [7] = R/W, [6:0] = register address
    localparam int RW_BIT   = 7;
    localparam int ADDR_MSB = 6;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
// Two-flop synchronizer for a signal asynchronous to clk, followed by an edge
// detector comparing the synchronized value with its previous value.
// Ports:
//   clk   in   system clock
//   din   in   asynchronous input
//   sync  out  synchronized level
//   rise  out  1-cycle pulse on a detected 0->1 transition
//   fall  out  1-cycle pulse on a detected 1->0 transition
// The flops are deliberately not reset: they keep tracking the pins through a
// system reset, so a reset taken while cs_n is low does not manufacture a
// false cs_n edge when it is released.
`timescale 1ns/1ps
module spi_sync_edge (
    input  logic clk,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        meta <= din;
        sync <= meta;
        prev <= sync;
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_responder.sv
// spi_reg_responder
// SPI mode-0 target backed by a small register bank. Each transaction is a
// command byte (R/W + address) followed by a data byte. While the command byte
// arrives the target shifts out a status byte; during the data byte it shifts
// out the addressed register as it was when the command completed.
// Ports:
//   clk       in   system clock (>= 8x sclk)
//   rst       in   synchronous active-high reset
//   cs_n      in   chip select, active low, asynchronous
//   sclk      in   SPI clock, CPOL=0, asynchronous
//   mosi      in   serial data in, MSB first
//   miso      out  serial data out, MSB first, 0 when not driven
//   miso_oe   out  miso drive enable, follows synchronized cs_n low
//   regs_out  out  flattened register bank, reg k at [8k+7:8k]
//   wr_pulse  out  1-cycle pulse when a register write commits
//   done      out  1-cycle pulse when a full 2-byte transaction is accepted
//   abort     out  1-cycle pulse when cs_n rises mid-transaction
`timescale 1ns/1ps
module spi_reg_responder
    import spi_pkg::*;
#(
    parameter int         NREGS       = 4,
    parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs_n,
    input  logic               sclk,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe,
    output logic [NREGS*8-1:0] regs_out,
    output logic               wr_pulse,
    output logic               done,
    output logic               abort
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    // Synchronized inputs and detected edges
    logic cs_sync, cs_rise, cs_fall;
    logic sclk_sync, sclk_rise_raw, sclk_fall_raw;
    logic mosi_meta, mosi_sync;
    logic sclk_rise, sclk_fall;

    // FSM and datapath state
    state_t            state, state_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        rx_shift, rx_shift_n;
    logic [7:0]        tx_shift, tx_shift_n;
    logic              rw, rw_n;
    logic [ADDR_MSB:0] addr, addr_n;
    logic              hold, hold_n;
    logic              miso_bit, miso_bit_n;
    logic              wr_pulse_n, done_n, abort_n;
    logic [7:0]        regs   [NREGS];
    logic [7:0]        regs_n [NREGS];
    logic [7:0]        rx_next;

    spi_sync_edge u_cs_sync (
        .clk  (clk),
        .din  (cs_n),
        .sync (cs_sync),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync_edge u_sclk_sync (
        .clk  (clk),
        .din  (sclk),
        .sync (sclk_sync),
        .rise (sclk_rise_raw),
        .fall (sclk_fall_raw)
    );

    // mosi only needs to be stable when an sclk rise is detected, so a plain
    // two-flop stage is enough; it has the same latency as the sclk path.
    always_ff @(posedge clk) begin
        mosi_meta <= mosi;
        mosi_sync <= mosi_meta;
    end

    // An sclk edge coinciding with cs_n rising belongs to a frame that is
    // already ending, so it is dropped. The level check is redundant with the
    // edge detector but keeps the qualification explicit.
    assign sclk_rise = sclk_rise_raw &  sclk_sync & ~cs_rise;
    assign sclk_fall = sclk_fall_raw & ~sclk_sync & ~cs_rise;

    assign rx_next = {rx_shift[6:0], mosi_sync};

    function automatic logic addr_ok(input logic [ADDR_MSB:0] a);
        return {25'd0, a} < NREGS;
    endfunction

    // Next-state logic. A "hold" flag marks that tx_shift was just reloaded
    // with the read value at the command/data boundary: the following fall
    // presents its MSB instead of shifting.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        rx_shift_n = rx_shift;
        tx_shift_n = tx_shift;
        rw_n       = rw;
        addr_n     = addr;
        hold_n     = hold;
        miso_bit_n = miso_bit;
        wr_pulse_n = 1'b0;
        done_n     = 1'b0;
        abort_n    = 1'b0;
        for (int k = 0; k < NREGS; k++) begin
            regs_n[k] = regs[k];
        end

        case (state)
            IDLE: begin
                miso_bit_n = 1'b0;
                if (cs_fall) begin
                    tx_shift_n = STATUS_BYTE;
                    miso_bit_n = STATUS_BYTE[7];
                    bit_cnt_n  = 3'd0;
                    hold_n     = 1'b0;
                    state_n    = CMD;
                end
            end

            CMD, DATA: begin
                if (cs_rise) begin
                    abort_n    = 1'b1;
                    miso_bit_n = 1'b0;
                    bit_cnt_n  = 3'd0;
                    hold_n     = 1'b0;
                    state_n    = IDLE;
                end else if (sclk_rise) begin
                    rx_shift_n = rx_next;
                    bit_cnt_n  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (state == CMD) begin
                            rw_n       = rx_next[RW_BIT];
                            addr_n     = rx_next[ADDR_MSB:0];
                            tx_shift_n = addr_ok(rx_next[ADDR_MSB:0]) ?
                                         regs[rx_next[AW-1:0]] : 8'h00;
                            hold_n     = 1'b1;
                            state_n    = DATA;
                        end else begin
                            if (rw == RW_WRITE && addr_ok(addr)) begin
                                regs_n[addr[AW-1:0]] = rx_next;
                                wr_pulse_n           = 1'b1;
                            end
                            done_n     = 1'b1;
                            miso_bit_n = 1'b0;
                            state_n    = WAIT_CS;
                        end
                    end
                end else if (sclk_fall) begin
                    if (hold) begin
                        miso_bit_n = tx_shift[7];
                        hold_n     = 1'b0;
                    end else begin
                        tx_shift_n = {tx_shift[6:0], 1'b0};
                        miso_bit_n = tx_shift[6];
                    end
                end
            end

            WAIT_CS: begin
                miso_bit_n = 1'b0;
                if (cs_rise) begin
                    bit_cnt_n = 3'd0;
                    state_n   = IDLE;
                end
            end

            default: begin
                miso_bit_n = 1'b0;
                state_n    = IDLE;
            end
        endcase
    end

    // State register; miso_oe is registered so that it is cleanly 0 in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            tx_shift <= 8'h00;
            rw       <= 1'b0;
            addr     <= '0;
            hold     <= 1'b0;
            miso_bit <= 1'b0;
            miso_oe  <= 1'b0;
            wr_pulse <= 1'b0;
            done     <= 1'b0;
            abort    <= 1'b0;
            for (int k = 0; k < NREGS; k++) begin
                regs[k] <= 8'h00;
            end
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            rx_shift <= rx_shift_n;
            tx_shift <= tx_shift_n;
            rw       <= rw_n;
            addr     <= addr_n;
            hold     <= hold_n;
            miso_bit <= miso_bit_n;
            miso_oe  <= ~cs_sync;
            wr_pulse <= wr_pulse_n;
            done     <= done_n;
            abort    <= abort_n;
            for (int k = 0; k < NREGS; k++) begin
                regs[k] <= regs_n[k];
            end
        end
    end

    assign miso = miso_oe & miso_bit;

    for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
        assign regs_out[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// tb_spi_reg_responder
// Directed bench for spi_reg_responder: acts as a mode-0 SPI initiator with an
// sclk half period of 8 system clocks and compares miso bytes, pulse counts and
// the exported register bank against hand-computed values.
`timescale 1ns/1ps
module tb_spi_reg_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [31:0] regs_out;
    logic        wr_pulse;
    logic        done;
    logic        abort;

    int assert_count = 0;
    int fail_count   = 0;
    int wr_count     = 0;
    int done_count   = 0;
    int abort_count  = 0;

    logic [7:0] rd0, rd1, rd2;

    spi_reg_responder #(.NREGS(4), .STATUS_BYTE(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .regs_out (regs_out),
        .wr_pulse (wr_pulse),
        .done     (done),
        .abort    (abort)
    );

    always #5 clk = ~clk;

    // Count output pulses on the falling edge, away from the register updates
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_pulse) wr_count++;
            if (done)     done_count++;
            if (abort)    abort_count++;
        end
    end

    // Hard bound on total run time
    initial begin
        #400us;
        $display("[TB] FAIL timeout: simulation did not finish, observed running, required finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic halfBit();
        repeat (8) @(negedge clk);
    endtask

    // Shift nbits of tx (MSB first) and capture miso at each rising sclk
    task automatic spiBits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            halfBit();
            rx   = {rx[6:0], miso};
            sclk = 1'b1;
            halfBit();
            sclk = 1'b0;
        end
    endtask

    // One complete two-byte transaction framed by cs_n
    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] data,
                                 output logic [7:0] r0, output logic [7:0] r1);
        cs_n = 1'b0;
        halfBit();
        spiBits(cmd, 8, r0);
        spiBits(data, 8, r1);
        halfBit();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        repeat (6) @(negedge clk);
        checkOutput("reset_miso",     {31'd0, miso},     32'd0);
        checkOutput("reset_miso_oe",  {31'd0, miso_oe},  32'd0);
        checkOutput("reset_regs",     regs_out,          32'd0);
        checkOutput("reset_wr_pulse", {31'd0, wr_pulse}, 32'd0);
        checkOutput("reset_done",     {31'd0, done},     32'd0);
        checkOutput("reset_abort",    {31'd0, abort},    32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Write 0x3C to reg2
        applyStimulus(8'h02, 8'h3C, rd0, rd1);
        checkOutput("wr_status", {24'd0, rd0}, 32'h0000_00A5);
        checkOutput("wr_rdval",  {24'd0, rd1}, 32'h0000_0000);
        checkOutput("wr_count",  wr_count,     32'd1);
        checkOutput("wr_done",   done_count,   32'd1);
        checkOutput("wr_regs",   regs_out,     32'h003C_0000);

        // Read back reg2
        applyStimulus(8'h82, 8'hFF, rd0, rd1);
        checkOutput("rd_status", {24'd0, rd0}, 32'h0000_00A5);
        checkOutput("rd_value",  {24'd0, rd1}, 32'h0000_003C);
        checkOutput("rd_wr",     wr_count,     32'd1);
        checkOutput("rd_done",   done_count,   32'd2);
        checkOutput("rd_regs",   regs_out,     32'h003C_0000);

        // Out-of-range write then read
        applyStimulus(8'h05, 8'h77, rd0, rd1);
        checkOutput("oor_wr_status", {24'd0, rd0}, 32'h0000_00A5);
        applyStimulus(8'h85, 8'h00, rd0, rd1);
        checkOutput("oor_rd_value", {24'd0, rd1}, 32'h0000_0000);
        checkOutput("oor_wr",       wr_count,     32'd1);
        checkOutput("oor_done",     done_count,   32'd4);
        checkOutput("oor_regs",     regs_out,     32'h003C_0000);

        // Abort after 3 data bits
        cs_n = 1'b0;
        halfBit();
        spiBits(8'h01, 8, rd0);
        spiBits(8'hA0, 3, rd1);
        halfBit();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("abort_count", abort_count, 32'd1);
        checkOutput("abort_done",  done_count,  32'd4);
        checkOutput("abort_wr",    wr_count,    32'd1);
        checkOutput("abort_regs",  regs_out,    32'h003C_0000);
        applyStimulus(8'h01, 8'h99, rd0, rd1);
        checkOutput("post_abort_wr",   wr_count,   32'd2);
        checkOutput("post_abort_done", done_count, 32'd5);
        checkOutput("post_abort_regs", regs_out,   32'h003C_9900);

        // Reset during the data byte of a write of 0x44 to reg0
        cs_n = 1'b0;
        halfBit();
        spiBits(8'h00, 8, rd0);
        spiBits(8'h44, 3, rd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("mid_rst_regs",     regs_out,          32'd0);
        checkOutput("mid_rst_miso_oe",  {31'd0, miso_oe},  32'd0);
        checkOutput("mid_rst_miso",     {31'd0, miso},     32'd0);
        checkOutput("mid_rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
        checkOutput("mid_rst_done",     {31'd0, done},     32'd0);
        checkOutput("mid_rst_abort",    {31'd0, abort},    32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        spiBits(8'h20, 5, rd1);
        spiBits(8'hFF, 8, rd2);
        halfBit();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("post_rst_wr",    wr_count,    32'd2);
        checkOutput("post_rst_done",  done_count,  32'd5);
        checkOutput("post_rst_abort", abort_count, 32'd1);
        checkOutput("post_rst_regs",  regs_out,    32'd0);
        applyStimulus(8'h00, 8'h44, rd0, rd1);
        checkOutput("recover_status", {24'd0, rd0}, 32'h0000_00A5);
        checkOutput("recover_wr",     wr_count,     32'd3);
        checkOutput("recover_regs",   regs_out,     32'h0000_0044);

        // Back-to-back transactions with a one-clock cs_n gap
        cs_n = 1'b0;
        halfBit();
        spiBits(8'h03, 8, rd0);
        spiBits(8'h5A, 8, rd1);
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
        cs_n = 1'b0;
        halfBit();
        spiBits(8'h83, 8, rd0);
        spiBits(8'h00, 8, rd1);
        halfBit();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("b2b_status", {24'd0, rd0}, 32'h0000_00A5);
        checkOutput("b2b_rdval",  {24'd0, rd1}, 32'h0000_005A);
        checkOutput("b2b_done",   done_count,   32'd8);
        checkOutput("b2b_wr",     wr_count,     32'd4);
        checkOutput("b2b_regs",   regs_out,     32'h5A00_0044);

        // 24-bit frame: third byte ignored, miso low during it
        cs_n = 1'b0;
        halfBit();
        spiBits(8'h00, 8, rd0);
        spiBits(8'h11, 8, rd1);
        spiBits(8'hFF, 8, rd2);
        halfBit();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("long_status", {24'd0, rd0}, 32'h0000_00A5);
        checkOutput("long_rdval",  {24'd0, rd1}, 32'h0000_0044);
        checkOutput("long_byte3",  {24'd0, rd2}, 32'h0000_0000);
        checkOutput("long_wr",     wr_count,     32'd5);
        checkOutput("long_done",   done_count,   32'd9);
        checkOutput("long_regs",   regs_out,     32'h5A00_0011);
        checkOutput("final_abort", abort_count,  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
